traffic_phase_sequencer: RTL and testbench

Parametrised four-way intersection controller: drives the NS and EW signal heads and their protected/permissive left-turn arrows from a timed phase FSM.
- Replaces fixed-decode light logic plus free-running arrow blink with configurable phase durations, demand-driven arrow phases, emergency preemption and night flash mode.
- Sits between the lane-sensor/request logic and the lamp driver outputs on the FPGA top level.

---
 rtl/traffic_phase_sequencer_if.sv | 25 ++
 rtl/traffic_phase_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_traffic_phase_sequencer.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_sequencer_if.sv
// Signal bundle between the lane-sensor/request logic and the intersection sequencer.
interface traffic_phase_sequencer_if;
    logic       left_req_ns;
    logic       left_req_ew;
    logic       preempt;
    logic       night_mode;
    logic [2:0] light_ns;
    logic [2:0] light_ew;
    logic       arrow_ns;
    logic       arrow_ew;
    logic [3:0] phase;
    logic       tick;

    // Request side: drives demands and mode requests, observes lamps.
    modport master (
        output left_req_ns, left_req_ew, preempt, night_mode,
        input  light_ns, light_ew, arrow_ns, arrow_ew, phase, tick
    );

    // Sequencer side.
    modport slave (
        input  left_req_ns, left_req_ew, preempt, night_mode,
        output light_ns, light_ew, arrow_ns, arrow_ew, phase, tick
    );
endinterface

// File: rtl/traffic_phase_sequencer.sv
// Four-way intersection controller: timed phase FSM with demand-driven left
// arrows, emergency preemption and night flash mode.
module traffic_phase_sequencer #(
    parameter int unsigned TICK_CYCLES = 100000000,
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned GREEN_T     = 20,
    parameter int unsigned YELLOW_T    = 3,
    parameter int unsigned ALLRED_T    = 2,
    parameter int unsigned ARROW_T     = 8
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    traffic_phase_sequencer_if.slave   bus
);

    localparam int unsigned PW = $clog2(TICK_CYCLES);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

    localparam logic [3:0] S_ALLRED0   = 4'd0;
    localparam logic [3:0] S_NS_ARROW  = 4'd1;
    localparam logic [3:0] S_NS_GREEN  = 4'd2;
    localparam logic [3:0] S_NS_YELLOW = 4'd3;
    localparam logic [3:0] S_ALLRED1   = 4'd4;
    localparam logic [3:0] S_EW_ARROW  = 4'd5;
    localparam logic [3:0] S_EW_GREEN  = 4'd6;
    localparam logic [3:0] S_EW_YELLOW = 4'd7;
    localparam logic [3:0] S_ALLRED2   = 4'd8;
    localparam logic [3:0] S_PREEMPT   = 4'd9;
    localparam logic [3:0] S_FLASH     = 4'd10;

    localparam logic [2:0] L_RED = 3'b100;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_OFF = 3'b000;

    logic [3:0]       state_q, state_nxt;
    logic [PW-1:0]    presc_q, presc_nxt;
    logic             tick_q, tick_nxt;
    logic [CNT_W-1:0] timer_q, timer_nxt;
    logic             blink_q, blink_nxt;
    logic             dem_ns_q, dem_ns_nxt;
    logic             dem_ew_q, dem_ew_nxt;
    logic [2:0]       light_ns_q, light_ns_c;
    logic [2:0]       light_ew_q, light_ew_c;
    logic             arrow_ns_q, arrow_ns_c;
    logic             arrow_ew_q, arrow_ew_c;
    logic             expired_c;
    logic             changed_c;

    assign expired_c = tick_q && (timer_q == '0);
    assign changed_c = (state_nxt != state_q);

    // State register.
    always_ff @(posedge CLK) begin
        if (!rst_n) state_q <= S_ALLRED0;
        else        state_q <= state_nxt;
    end

    // Next-state: preemption beats night mode beats arrow demand.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_ALLRED0, S_ALLRED2: begin
                if (expired_c) begin
                    if (bus.preempt)         state_nxt = S_PREEMPT;
                    else if (bus.night_mode) state_nxt = S_FLASH;
                    else                     state_nxt = dem_ns_q ? S_NS_ARROW : S_NS_GREEN;
                end
            end
            S_ALLRED1: begin
                if (expired_c) begin
                    if (bus.preempt)         state_nxt = S_PREEMPT;
                    else if (bus.night_mode) state_nxt = S_FLASH;
                    else                     state_nxt = dem_ew_q ? S_EW_ARROW : S_EW_GREEN;
                end
            end
            S_NS_ARROW: begin
                if (bus.preempt)    state_nxt = S_NS_YELLOW;
                else if (expired_c) state_nxt = S_NS_GREEN;
            end
            S_NS_GREEN:  if (bus.preempt || expired_c) state_nxt = S_NS_YELLOW;
            S_NS_YELLOW: if (expired_c) state_nxt = S_ALLRED1;
            S_EW_ARROW: begin
                if (bus.preempt)    state_nxt = S_EW_YELLOW;
                else if (expired_c) state_nxt = S_EW_GREEN;
            end
            S_EW_GREEN:  if (bus.preempt || expired_c) state_nxt = S_EW_YELLOW;
            S_EW_YELLOW: if (expired_c) state_nxt = S_ALLRED2;
            S_PREEMPT:   if (!bus.preempt) state_nxt = S_ALLRED0;
            S_FLASH: begin
                if (bus.preempt)                      state_nxt = S_PREEMPT;
                else if (tick_q && !bus.night_mode)   state_nxt = S_ALLRED0;
            end
            default:     state_nxt = S_ALLRED0;
        endcase
    end

    // Prescaler, phase timer, blink phase and demand latches; a state change restarts timing.
    always_comb begin
        presc_nxt = (changed_c || (presc_q == PRESC_LAST)) ? '0 : presc_q + PW'(1);
        tick_nxt  = (presc_nxt == PRESC_LAST);
        blink_nxt = changed_c ? 1'b1 : (blink_q ^ tick_q);
        timer_nxt = timer_q;
        if (changed_c) begin
            case (state_nxt)
                S_NS_ARROW, S_EW_ARROW:           timer_nxt = CNT_W'(ARROW_T - 1);
                S_NS_GREEN, S_EW_GREEN:           timer_nxt = CNT_W'(GREEN_T - 1);
                S_NS_YELLOW, S_EW_YELLOW:         timer_nxt = CNT_W'(YELLOW_T - 1);
                S_ALLRED0, S_ALLRED1, S_ALLRED2:  timer_nxt = CNT_W'(ALLRED_T - 1);
                default:                          timer_nxt = '0;
            endcase
        end else if (tick_q && (timer_q != '0)) begin
            timer_nxt = timer_q - CNT_W'(1);
        end
        // A request in the final arrow cycle survives the clear.
        dem_ns_nxt = bus.left_req_ns | (dem_ns_q & ~(changed_c && (state_q == S_NS_ARROW)));
        dem_ew_nxt = bus.left_req_ew | (dem_ew_q & ~(changed_c && (state_q == S_EW_ARROW)));
    end

    // Lamp decode for the upcoming state, registered alongside the state.
    always_comb begin
        light_ns_c = L_RED;
        light_ew_c = L_RED;
        arrow_ns_c = 1'b0;
        arrow_ew_c = 1'b0;
        case (state_nxt)
            S_NS_ARROW:  arrow_ns_c = 1'b1;
            S_NS_GREEN: begin
                light_ns_c = L_GRN;
                arrow_ns_c = blink_nxt;
            end
            S_NS_YELLOW: light_ns_c = L_YEL;
            S_EW_ARROW:  arrow_ew_c = 1'b1;
            S_EW_GREEN: begin
                light_ew_c = L_GRN;
                arrow_ew_c = blink_nxt;
            end
            S_EW_YELLOW: light_ew_c = L_YEL;
            S_FLASH: begin
                light_ns_c = blink_nxt ? L_YEL : L_OFF;
                light_ew_c = blink_nxt ? L_RED : L_OFF;
            end
            default: ;
        endcase
    end

    // Timing, latch and output registers.
    always_ff @(posedge CLK) begin
        if (!rst_n) begin
            presc_q    <= '0;
            tick_q     <= 1'b0;
            timer_q    <= '0;
            blink_q    <= 1'b0;
            dem_ns_q   <= 1'b0;
            dem_ew_q   <= 1'b0;
            light_ns_q <= L_RED;
            light_ew_q <= L_RED;
            arrow_ns_q <= 1'b0;
            arrow_ew_q <= 1'b0;
        end else begin
            presc_q    <= presc_nxt;
            tick_q     <= tick_nxt;
            timer_q    <= timer_nxt;
            blink_q    <= blink_nxt;
            dem_ns_q   <= dem_ns_nxt;
            dem_ew_q   <= dem_ew_nxt;
            light_ns_q <= light_ns_c;
            light_ew_q <= light_ew_c;
            arrow_ns_q <= arrow_ns_c;
            arrow_ew_q <= arrow_ew_c;
        end
    end

    assign bus.light_ns = light_ns_q;
    assign bus.light_ew = light_ew_q;
    assign bus.arrow_ns = arrow_ns_q;
    assign bus.arrow_ew = arrow_ew_q;
    assign bus.phase    = state_q;
    assign bus.tick     = tick_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Randomised scoreboard bench for the intersection sequencer.
module tb_traffic_phase_sequencer;

    localparam int T   = 4;
    localparam int GT  = 3;
    localparam int YT  = 2;
    localparam int ART = 1;
    localparam int AWT = 2;

    logic CLK = 1'b0;
    logic rst_n;

    traffic_phase_sequencer_if bus ();

    traffic_phase_sequencer #(
        .TICK_CYCLES(T), .CNT_W(8), .GREEN_T(GT), .YELLOW_T(YT),
        .ALLRED_T(ART), .ARROW_T(AWT)
    ) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Reference model: phase code, cycles spent in it, demand memory.
    int m_phase = 0;
    int m_cyc   = 0;
    bit m_dem_ns = 1'b0;
    bit m_dem_ew = 1'b0;

    logic [12:0] exp_q[$];

    function automatic int dur_of(input int p);
        case (p)
            1, 5:    return AWT;
            2, 6:    return GT;
            3, 7:    return YT;
            default: return ART;
        endcase
    endfunction

    // Expected {phase, light_ns, light_ew, arrow_ns, arrow_ew, tick}.
    function automatic logic [12:0] exp_vec(input int p, input int c);
        logic       on;
        logic       tk;
        logic [2:0] ns;
        logic [2:0] ew;
        logic       an;
        logic       ae;
        on = ((c / T) % 2) == 0;
        tk = (c % T) == (T - 1);
        ns = 3'b100;
        ew = 3'b100;
        an = 1'b0;
        ae = 1'b0;
        case (p)
            1:  an = 1'b1;
            2:  begin ns = 3'b001; an = on; end
            3:  ns = 3'b010;
            5:  ae = 1'b1;
            6:  begin ew = 3'b001; ae = on; end
            7:  ew = 3'b010;
            10: begin ns = on ? 3'b010 : 3'b000; ew = on ? 3'b100 : 3'b000; end
            default: ;
        endcase
        return {4'(p), ns, ew, an, ae, tk};
    endfunction

    // One clock of stimulus; the model predicts the outputs after the next edge.
    task automatic step(input bit r, input bit ln, input bit le, input bit pr, input bit nt);
        bit tk;
        bit done;
        int np;
        @(negedge CLK);
        rst_n           = r;
        bus.left_req_ns = ln;
        bus.left_req_ew = le;
        bus.preempt     = pr;
        bus.night_mode  = nt;
        if (!r) begin
            m_phase  = 0;
            m_cyc    = 0;
            m_dem_ns = 1'b0;
            m_dem_ew = 1'b0;
        end else begin
            tk   = (m_cyc % T) == (T - 1);
            done = tk && ((m_cyc + 1) == dur_of(m_phase) * T);
            np   = m_phase;
            case (m_phase)
                0, 4, 8: if (done) np = pr ? 9 : nt ? 10 :
                                        (m_phase == 4) ? (m_dem_ew ? 5 : 6) : (m_dem_ns ? 1 : 2);
                1:  if (pr) np = 3; else if (done) np = 2;
                2:  if (pr || done) np = 3;
                3:  if (done) np = 4;
                5:  if (pr) np = 7; else if (done) np = 6;
                6:  if (pr || done) np = 7;
                7:  if (done) np = 8;
                9:  if (!pr) np = 0;
                10: if (pr) np = 9; else if (tk && !nt) np = 0;
                default: np = 0;
            endcase
            m_dem_ns = ln | (m_dem_ns & !(m_phase == 1 && np != 1));
            m_dem_ew = le | (m_dem_ew & !(m_phase == 5 && np != 5));
            m_cyc    = (np != m_phase) ? 0 : m_cyc + 1;
            m_phase  = np;
        end
        exp_q.push_back(exp_vec(m_phase, m_cyc));
    endtask

    task automatic run(input int n, input bit pr, input bit nt);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, pr, nt);
    endtask

    task automatic run_until(input int p, input bit pr, input bit nt);
        int n;
        n = 0;
        while (m_phase != p && n < 300) begin
            step(1'b1, 1'b0, 1'b0, pr, nt);
            n++;
        end
        total++;
        if (m_phase != p) begin
            bad++;
            $display("FAIL reach_phase got=%0d want=%0d", m_phase, p);
        end
    endtask

    // Monitor: compare every presented output against the queued prediction.
    initial begin
        logic [12:0] e;
        logic [12:0] a;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {bus.phase, bus.light_ns, bus.light_ew, bus.arrow_ns, bus.arrow_ew, bus.tick};
                total++;
                if (a !== e) begin
                    bad++;
                    $display("FAIL outputs t=%0t act={ph=%0d ns=%b ew=%b an=%b ae=%b tk=%b} exp={ph=%0d ns=%b ew=%b an=%b ae=%b tk=%b}",
                             $time, a[12:9], a[8:6], a[5:3], a[2], a[1], a[0],
                             e[12:9], e[8:6], e[5:3], e[2], e[1], e[0]);
                end
                total++;
                if (bus.arrow_ns && bus.arrow_ew) begin
                    bad++;
                    $display("FAIL both_arrows t=%0t an=%b ae=%b", $time, bus.arrow_ns, bus.arrow_ew);
                end
                if (bus.phase != 4'd10) begin
                    total++;
                    if (bus.light_ns != 3'b100 && bus.light_ew != 3'b100) begin
                        bad++;
                        $display("FAIL both_heads_open t=%0t ns=%b ew=%b", $time, bus.light_ns, bus.light_ew);
                    end
                    total++;
                    if ($countones(bus.light_ns) > 1 || $countones(bus.light_ew) > 1) begin
                        bad++;
                        $display("FAIL onehot t=%0t ns=%b ew=%b", $time, bus.light_ns, bus.light_ew);
                    end
                end
            end
        end
    end

    initial begin
        bit pr;
        bit nt;
        int n;
        rst_n           = 1'b0;
        bus.left_req_ns = 1'b0;
        bus.left_req_ew = 1'b0;
        bus.preempt     = 1'b0;
        bus.night_mode  = 1'b0;

        // Reset, then an undisturbed NS/EW cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_until(6, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);
        // NS left demand pulse during EW green; arrow served then skipped next time.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        run_until(1, 1'b0, 1'b0);
        run(120, 1'b0, 1'b0);

        // Preemption mid NS green.
        run_until(2, 1'b0, 1'b0);
        run(5, 1'b0, 1'b0);
        run(40, 1'b1, 1'b0);
        run(30, 1'b0, 1'b0);

        // Night flash entered from the NS cycle, then released.
        run_until(2, 1'b0, 1'b0);
        run(60, 1'b0, 1'b1);
        run(20, 1'b0, 1'b0);

        // Both demands, then reset in the middle of the EW arrow.
        run_until(2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        run_until(5, 1'b0, 1'b0);
        run(3, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run(70, 1'b0, 1'b0);

        // Long random run of demands, preemption, night mode and rare resets.
        pr = 1'b0;
        nt = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(99) == 0)  pr = !pr;
            if ($urandom_range(149) == 0) nt = !nt;
            step($urandom_range(1999) != 0, $urandom_range(15) == 0,
                 $urandom_range(15) == 0, pr, nt);
        end
        run(80, 1'b0, 1'b0);

        // Drain the scoreboard with a bounded wait.
        n = 0;
        while (exp_q.size() > 0 && n < 10) begin
            @(posedge CLK);
            n++;
        end
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
